// File: rtl/serv_rf_ram_arb_pkg.sv
// Shared definitions for the RF RAM core/host arbiter and serv_rf_ram_if.
// The optional range check is enabled in serv_rf_ram_arb by SERV_RF_ARB_RANGE_EN.
package serv_rf_ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_ACK  = 2'd3
    } arb_state_t;

    localparam int REG_BITS   = 32;
    localparam int HOST_ADR_W = 6;

    function automatic int rows_per_reg(input int w);
        return REG_BITS / w;
    endfunction

    function automatic int part_bits(input int w);
        return $clog2(REG_BITS / w);
    endfunction

    // Row address {reg, part}; the caller truncates to its own address width.
    function automatic logic [31:0] row_addr(input logic [31:0] reg_idx,
                                             input logic [31:0] part,
                                             input int          pw);
        return (reg_idx << pw) | part;
    endfunction

endpackage

// File: rtl/serv_rf_ram_arb.sv
// Shares the RF RAM between the core (strict priority per port) and a 32-bit host port.
// Optional macro SERV_RF_ARB_RANGE_EN adds a range check and the o_host_err output.
//
// state   | meaning
// IDLE    | waiting for i_host_cyc
// RD      | issuing host row reads into free read-port slots, capturing data
// WR      | issuing host row writes into free write-port slots
// ACK     | one-cycle completion pulse to the host
module serv_rf_ram_arb
    import serv_rf_ram_arb_pkg::*;
#(
    parameter int width    = 2,
    parameter int csr_regs = 4,
    parameter int l2d      = $clog2((32 + csr_regs) * 32 / width)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [l2d-1:0]        i_core_waddr,
    input  logic [width-1:0]      i_core_wdata,
    input  logic                  i_core_wen,
    input  logic [l2d-1:0]        i_core_raddr,
    input  logic                  i_core_ren,
    output logic [width-1:0]      o_core_rdata,
    output logic [l2d-1:0]        o_ram_waddr,
    output logic [width-1:0]      o_ram_wdata,
    output logic                  o_ram_wen,
    output logic [l2d-1:0]        o_ram_raddr,
    output logic                  o_ram_ren,
    input  logic [width-1:0]      i_ram_rdata,
    input  logic [HOST_ADR_W-1:0] i_host_adr,
    input  logic [31:0]           i_host_dat,
    input  logic                  i_host_we,
    input  logic                  i_host_cyc,
    output logic [31:0]           o_host_rdt,
    output logic                  o_host_ack
`ifdef SERV_RF_ARB_RANGE_EN
    ,
    output logic                  o_host_err
`endif
);

    localparam int          N         = rows_per_reg(width);
    localparam int          PW        = part_bits(width);
    localparam int          CW        = PW + 1;
    localparam logic [CW-1:0] LP_N    = CW'(N);
    localparam logic [CW-1:0] LP_LAST = CW'(N - 1);
    localparam int          REG_LIMIT = 32 + csr_regs;

    arb_state_t            r_state;
    logic [HOST_ADR_W-1:0] r_adr;
    logic [31:0]           r_dsh;
    logic [31:0]           r_buf;
    logic [31:0]           r_rdt;
    logic [CW-1:0]         r_icnt;
    logic [CW-1:0]         r_ccnt;
    logic                  r_rd_pend;
    logic                  r_ack;
`ifdef SERV_RF_ARB_RANGE_EN
    logic                  r_err;
`endif

    logic                  w_issue_ok;
    logic                  w_host_ren;
    logic                  w_host_wen;
    logic [l2d-1:0]        w_host_row;
    logic [31:0]           w_buf_next;

    assign w_issue_ok = (r_icnt < LP_N);
    assign w_host_ren = (r_state == ST_RD) && !i_core_ren && w_issue_ok;
    // x0 is hardwired zero, so host writes to it never touch the RAM.
    assign w_host_wen = (r_state == ST_WR) && !i_core_wen && w_issue_ok && (r_adr != '0);
    assign w_host_row = l2d'(row_addr(32'(r_adr), 32'(r_icnt), PW));
    assign w_buf_next = 32'({i_ram_rdata, r_buf} >> width);

    assign o_core_rdata = i_ram_rdata;
    assign o_ram_ren    = i_core_ren | w_host_ren;
    assign o_ram_raddr  = i_core_ren ? i_core_raddr : w_host_row;
    assign o_ram_wen    = i_core_wen | w_host_wen;
    assign o_ram_waddr  = i_core_wen ? i_core_waddr : w_host_row;
    assign o_ram_wdata  = i_core_wen ? i_core_wdata : r_dsh[width-1:0];
    assign o_host_ack   = r_ack;
    assign o_host_rdt   = r_rdt;
`ifdef SERV_RF_ARB_RANGE_EN
    assign o_host_err   = r_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_adr     <= '0;
            r_dsh     <= '0;
            r_buf     <= '0;
            r_rdt     <= '0;
            r_icnt    <= '0;
            r_ccnt    <= '0;
            r_rd_pend <= 1'b0;
            r_ack     <= 1'b0;
`ifdef SERV_RF_ARB_RANGE_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_rd_pend <= w_host_ren;
            case (r_state)
                ST_IDLE: begin
                    if (i_host_cyc) begin
                        r_adr  <= i_host_adr;
                        r_dsh  <= i_host_dat;
                        r_icnt <= '0;
                        r_ccnt <= '0;
`ifdef SERV_RF_ARB_RANGE_EN
                        if (int'(i_host_adr) >= REG_LIMIT) begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_rdt   <= '0;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= i_host_we ? ST_WR : ST_RD;
                        end
`else
                        r_state <= i_host_we ? ST_WR : ST_RD;
`endif
                    end
                end
                ST_RD: begin
                    if (w_host_ren) begin
                        r_icnt <= r_icnt + CW'(1);
                    end
                    // Data for a host-issued read lands one cycle after its issue.
                    if (r_rd_pend) begin
                        r_buf  <= w_buf_next;
                        r_ccnt <= r_ccnt + CW'(1);
                        if (r_ccnt == LP_LAST) begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_rdt   <= w_buf_next;
                        end
                    end
                end
                ST_WR: begin
                    if (r_adr == '0) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_rdt   <= r_buf;
                    end else if (w_host_wen) begin
                        r_dsh  <= r_dsh >> width;
                        r_icnt <= r_icnt + CW'(1);
                        if (r_icnt == LP_LAST) begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_rdt   <= r_buf;
                        end
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
`ifdef SERV_RF_ARB_RANGE_EN
                    r_err   <= 1'b0;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// Bench for serv_rf_ram_arb with a behavioural RF RAM and per-register reference model.
// Build with SERV_RF_ARB_RANGE_EN defined to exercise the range check as well.
module tb_serv_rf_ram_arb;

    localparam int WIDTH  = 2;
    localparam int CSR    = 4;
    localparam int N      = 32 / WIDTH;
    localparam int L2D    = $clog2((32 + CSR) * N);
    localparam int DEPTH  = 1 << L2D;
    localparam int PATLEN = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [L2D-1:0]   core_waddr, core_raddr;
    logic [WIDTH-1:0] core_wdata;
    logic             core_wen, core_ren;
    logic [WIDTH-1:0] core_rdata;
    logic [L2D-1:0]   ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_wen, ram_ren;
    logic [WIDTH-1:0] ram_rdata;
    logic [5:0]       host_adr;
    logic [31:0]      host_dat;
    logic             host_we, host_cyc;
    logic [31:0]      host_rdt;
    logic             host_ack;
    logic             host_err;

    serv_rf_ram_arb #(.width(WIDTH), .csr_regs(CSR)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_core_waddr (core_waddr),
        .i_core_wdata (core_wdata),
        .i_core_wen   (core_wen),
        .i_core_raddr (core_raddr),
        .i_core_ren   (core_ren),
        .o_core_rdata (core_rdata),
        .o_ram_waddr  (ram_waddr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_wen    (ram_wen),
        .o_ram_raddr  (ram_raddr),
        .o_ram_ren    (ram_ren),
        .i_ram_rdata  (ram_rdata),
        .i_host_adr   (host_adr),
        .i_host_dat   (host_dat),
        .i_host_we    (host_we),
        .i_host_cyc   (host_cyc),
        .o_host_rdt   (host_rdt),
`ifdef SERV_RF_ARB_RANGE_EN
        .o_host_err   (host_err),
`endif
        .o_host_ack   (host_ack)
    );
`ifndef SERV_RF_ARB_RANGE_EN
    assign host_err = 1'b0;
`endif

    // Behavioural RF RAM with a bench-only preload port.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic             mem_clr, pre_we;
    logic [L2D-1:0]   pre_addr;
    logic [WIDTH-1:0] pre_data;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_wen) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_regs [0:63];

    logic             pat_ren   [0:PATLEN-1];
    logic             pat_wen   [0:PATLEN-1];
    logic [L2D-1:0]   pat_raddr [0:PATLEN-1];
    logic [L2D-1:0]   pat_waddr [0:PATLEN-1];
    logic [WIDTH-1:0] pat_wdata [0:PATLEN-1];

    int               ack_cyc;
    logic [31:0]      rdt_seen;
    logic             err_seen;
    int               hwen_cnt;
    int               pass_err;
    logic [L2D-1:0]   hren_q [$];
    logic [WIDTH-1:0] core_rd_q [$];

    function automatic logic [31:0] mem_reg(input int idx);
        logic [31:0] v = '0;
        for (int j = 0; j < N; j++) v = v | (32'(mem[idx*N + j]) << (WIDTH*j));
        return v;
    endfunction

    // Cycle of the ack: the host needs N free cycles on its port, counted from cycle 1.
    function automatic int exp_ack(input logic [5:0] adr, input logic we);
        int free = 0;
`ifdef SERV_RF_ARB_RANGE_EN
        if (int'(adr) >= 32 + CSR) return 1;
`endif
        if (we && adr == 6'd0) return 2;
        for (int k = 1; k < PATLEN; k++) begin
            if (!(we ? pat_wen[k] : pat_ren[k])) begin
                free++;
                if (free == N) return we ? k + 1 : k + 2;
            end
        end
        return -2;
    endfunction

    task automatic clear_pat();
        for (int k = 0; k < PATLEN; k++) begin
            pat_ren[k] = 1'b0; pat_wen[k] = 1'b0;
            pat_raddr[k] = '0; pat_waddr[k] = '0; pat_wdata[k] = '0;
        end
    endtask

    task automatic drive_core(input int k);
        core_ren   = pat_ren[k];
        core_raddr = pat_raddr[k];
        core_wen   = pat_wen[k];
        core_waddr = pat_waddr[k];
        core_wdata = pat_wdata[k];
    endtask

    task automatic set_reg(input int idx, input logic [31:0] val);
        for (int j = 0; j < N; j++) begin
            pre_we   = 1'b1;
            pre_addr = L2D'(idx*N + j);
            pre_data = val[WIDTH*j +: WIDTH];
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        ref_regs[idx] = val;
    endtask

    // Runs one host access with the current core pattern; cycle 0 is the cycle cyc rises.
    task automatic host_txn(input logic [5:0] adr, input logic [31:0] dat, input logic we);
        int   cn;
        logic prev_cren;
        ack_cyc = -1; hwen_cnt = 0; pass_err = 0; err_seen = 1'b0; rdt_seen = '0;
        hren_q.delete(); core_rd_q.delete();
        prev_cren = 1'b0;
        host_adr = adr; host_dat = dat; host_we = we; host_cyc = 1'b1;
        cn = 0;
        drive_core(0);
        while (cn < PATLEN - 1) begin
            @(negedge clk);
            if (prev_cren) core_rd_q.push_back(core_rdata);
            prev_cren = core_ren;
            if (core_ren && ram_raddr !== core_raddr) pass_err++;
            if (core_wen && (ram_waddr !== core_waddr || ram_wdata !== core_wdata)) pass_err++;
            if (ram_ren && !core_ren) hren_q.push_back(ram_raddr);
            if (ram_wen && !core_wen) hwen_cnt++;
            if (host_ack === 1'b1) begin
                ack_cyc = cn; rdt_seen = host_rdt; err_seen = host_err;
            end
            @(posedge clk); #1;
            cn++;
            if (ack_cyc >= 0) break;
            drive_core(cn);
        end
        host_cyc = 1'b0; core_ren = 1'b0; core_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        host_cyc = 1'b0; host_we = 1'b0; host_adr = '0; host_dat = '0;
        core_ren = 1'b0; core_wen = 1'b0; core_raddr = '0; core_waddr = '0; core_wdata = '0;
        for (int i = 0; i < 64; i++) ref_regs[i] = '0;
        clear_pat();
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", host_ack); end
        total++; if (host_rdt !== 32'h0) begin bad++; $display("FAIL reset_rdt: got %h want 0", host_rdt); end
        total++; if (ram_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", ram_wen); end
        total++; if (ram_ren !== 1'b0) begin bad++; $display("FAIL reset_ren: got %b want 0", ram_ren); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        clear_pat();
        set_reg(5, 32'hDEADBEEF);
        host_txn(6'd5, 32'h0, 1'b0);
        total++; if (ack_cyc !== 18) begin bad++; $display("FAIL rd_ack_cycle: got %0d want 18", ack_cyc); end
        total++; if (rdt_seen !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rdt_seen); end
        total++; if (hren_q.size() !== N) begin bad++; $display("FAIL rd_ren_count: got %0d want %0d", hren_q.size(), N); end
        for (int j = 0; j < hren_q.size() && j < N; j++) begin
            total++;
            if (hren_q[j] !== L2D'(5*N + j)) begin
                bad++; $display("FAIL rd_raddr[%0d]: got %0d want %0d", j, hren_q[j], 5*N + j);
            end
        end
        @(negedge clk);
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_width: got %b want 0", host_ack); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_basic();
        clear_pat();
        host_txn(6'd7, 32'h12345678, 1'b1);
        ref_regs[7] = 32'h12345678;
        total++; if (ack_cyc !== 17) begin bad++; $display("FAIL wr_ack_cycle: got %0d want 17", ack_cyc); end
        total++; if (hwen_cnt !== N) begin bad++; $display("FAIL wr_wen_count: got %0d want %0d", hwen_cnt, N); end
        total++; if (mem[7*N] !== 2'b00) begin bad++; $display("FAIL wr_row0: got %b want 00", mem[7*N]); end
        total++; if (mem[7*N + N-1] !== 2'b00) begin bad++; $display("FAIL wr_row15: got %b want 00", mem[7*N + N-1]); end
        total++; if (mem_reg(7) !== 32'h12345678) begin bad++; $display("FAIL wr_mem: got %h want 12345678", mem_reg(7)); end
        host_txn(6'd7, 32'h0, 1'b0);
        total++; if (rdt_seen !== 32'h12345678) begin bad++; $display("FAIL wr_readback: got %h want 12345678", rdt_seen); end
    endtask

    task automatic test_read_stall();
        clear_pat();
        for (int k = 3; k <= 12; k++) begin
            pat_ren[k]   = 1'b1;
            pat_raddr[k] = L2D'(5*N + (k - 3));
        end
        host_txn(6'd5, 32'h0, 1'b0);
        total++; if (ack_cyc !== 28) begin bad++; $display("FAIL stall_ack_cycle: got %0d want 28", ack_cyc); end
        total++; if (rdt_seen !== ref_regs[5]) begin bad++; $display("FAIL stall_data: got %h want %h", rdt_seen, ref_regs[5]); end
        total++; if (pass_err !== 0) begin bad++; $display("FAIL stall_passthrough: got %0d want 0", pass_err); end
        total++; if (hren_q.size() !== N) begin bad++; $display("FAIL stall_ren_count: got %0d want %0d", hren_q.size(), N); end
        total++; if (core_rd_q.size() !== 10) begin bad++; $display("FAIL stall_core_rd_count: got %0d want 10", core_rd_q.size()); end
        for (int j = 0; j < core_rd_q.size() && j < 10; j++) begin
            total++;
            if (core_rd_q[j] !== WIDTH'(ref_regs[5] >> (WIDTH*j))) begin
                bad++; $display("FAIL stall_core_rdata[%0d]: got %b want %b", j, core_rd_q[j], WIDTH'(ref_regs[5] >> (WIDTH*j)));
            end
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] v9;
        clear_pat();
        set_reg(3, $urandom);
        v9 = $urandom;
        for (int k = 1; k <= N; k++) begin
            pat_wen[k]   = 1'b1;
            pat_waddr[k] = L2D'(9*N + (k - 1));
            pat_wdata[k] = v9[WIDTH*(k-1) +: WIDTH];
        end
        host_txn(6'd3, 32'h0, 1'b0);
        ref_regs[9] = v9;
        total++; if (ack_cyc !== 18) begin bad++; $display("FAIL conc_ack_cycle: got %0d want 18", ack_cyc); end
        total++; if (rdt_seen !== ref_regs[3]) begin bad++; $display("FAIL conc_x3: got %h want %h", rdt_seen, ref_regs[3]); end
        total++; if (mem_reg(9) !== v9) begin bad++; $display("FAIL conc_x9_mem: got %h want %h", mem_reg(9), v9); end
        total++; if (pass_err !== 0) begin bad++; $display("FAIL conc_passthrough: got %0d want 0", pass_err); end
        clear_pat();
        host_txn(6'd9, 32'h0, 1'b0);
        total++; if (rdt_seen !== v9) begin bad++; $display("FAIL conc_x9_host: got %h want %h", rdt_seen, v9); end
    endtask

    task automatic test_x0_write();
        clear_pat();
        host_txn(6'd0, 32'hFFFFFFFF, 1'b1);
        total++; if (ack_cyc !== 2) begin bad++; $display("FAIL x0_ack_cycle: got %0d want 2", ack_cyc); end
        total++; if (hwen_cnt !== 0) begin bad++; $display("FAIL x0_wen_count: got %0d want 0", hwen_cnt); end
        host_txn(6'd0, 32'h0, 1'b0);
        total++; if (rdt_seen !== 32'h0) begin bad++; $display("FAIL x0_read: got %h want 0", rdt_seen); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old_v, new_v, exp_v, mask;
        clear_pat();
        old_v = $urandom;
        new_v = ~old_v;
        set_reg(11, old_v);
        host_adr = 6'd11; host_dat = new_v; host_we = 1'b1; host_cyc = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; host_cyc = 1'b0;
        @(negedge clk);
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack: got %b want 0", host_ack); end
        total++; if (ram_wen !== 1'b0) begin bad++; $display("FAIL rstmid_wen: got %b want 0", ram_wen); end
        total++; if (ram_ren !== 1'b0) begin bad++; $display("FAIL rstmid_ren: got %b want 0", ram_ren); end
        total++; if (host_rdt !== 32'h0) begin bad++; $display("FAIL rstmid_rdt: got %h want 0", host_rdt); end
        @(posedge clk); #1;
        mask  = (32'h1 << (5*WIDTH)) - 32'h1;
        exp_v = (old_v & ~mask) | (new_v & mask);
        ref_regs[11] = exp_v;
        total++; if (mem_reg(11) !== exp_v) begin bad++; $display("FAIL rstmid_partial: got %h want %h", mem_reg(11), exp_v); end
        host_txn(6'd11, 32'h0, 1'b0);
        total++; if (rdt_seen !== exp_v) begin bad++; $display("FAIL rstmid_read: got %h want %h", rdt_seen, exp_v); end
    endtask

`ifdef SERV_RF_ARB_RANGE_EN
    task automatic test_range();
        clear_pat();
        host_txn(6'd40, $urandom, 1'($urandom_range(0, 1)));
        total++; if (ack_cyc !== 1) begin bad++; $display("FAIL range_ack_cycle: got %0d want 1", ack_cyc); end
        total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL range_err: got %b want 1", err_seen); end
        total++; if (rdt_seen !== 32'h0) begin bad++; $display("FAIL range_rdt: got %h want 0", rdt_seen); end
        total++; if (hren_q.size() + hwen_cnt !== 0) begin bad++; $display("FAIL range_ram_access: got %0d want 0", hren_q.size() + hwen_cnt); end
        @(negedge clk);
        total++; if (host_err !== 1'b0) begin bad++; $display("FAIL range_err_width: got %b want 0", host_err); end
        @(posedge clk); #1;
    endtask
`endif

    // Random host traffic on x0-x19 and the CSR file; core traffic confined to x20-x31.
    task automatic test_random();
        logic [5:0]  adr;
        logic [31:0] dat;
        logic        we;
        int          r, exp;
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < PATLEN; k++) begin
                pat_ren[k]   = ($urandom_range(0, 2) == 0);
                pat_raddr[k] = L2D'((20 + $urandom_range(0, 11))*N + $urandom_range(0, N-1));
                pat_wen[k]   = ($urandom_range(0, 2) == 0);
                pat_waddr[k] = L2D'((20 + $urandom_range(0, 11))*N + $urandom_range(0, N-1));
                pat_wdata[k] = WIDTH'($urandom);
            end
            r   = $urandom_range(0, 23);
            adr = (r < 20) ? 6'(r) : 6'(32 + r - 20);
            we  = 1'($urandom_range(0, 1));
            dat = $urandom;
            exp = exp_ack(adr, we);
            host_txn(adr, dat, we);
            total++; if (ack_cyc !== exp) begin bad++; $display("FAIL rand_ack[%0d]: got %0d want %0d", t, ack_cyc, exp); end
            total++; if (pass_err !== 0) begin bad++; $display("FAIL rand_passthrough[%0d]: got %0d want 0", t, pass_err); end
            if (!we) begin
                total++;
                if (rdt_seen !== ref_regs[adr]) begin
                    bad++; $display("FAIL rand_rdt[%0d] x%0d: got %h want %h", t, adr, rdt_seen, ref_regs[adr]);
                end
            end else if (adr != 6'd0) begin
                ref_regs[adr] = dat;
            end
        end
        for (int i = 1; i < 20; i++) begin
            total++;
            if (mem_reg(i) !== ref_regs[i]) begin
                bad++; $display("FAIL rand_final_x%0d: got %h want %h", i, mem_reg(i), ref_regs[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_read_stall();
        test_concurrent();
        test_x0_write();
        test_reset_mid();
`ifdef SERV_RF_ARB_RANGE_EN
        test_range();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
